// File: rtl/display_serializer_if.sv
`default_nettype none
//==============================================================================
// display_serializer_if: digit/control inputs and serial display outputs.
// Rev 1.0
//==============================================================================
interface display_serializer_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    blank_en;
    logic                    start;
    logic                    auto_refresh;
    logic                    sdata;
    logic                    sclk;
    logic                    latch;
    logic                    busy;
    logic                    frame_done;

    modport master (
        output bcd_in, dp_in, blank_en, start, auto_refresh,
        input  sdata, sclk, latch, busy, frame_done
    );

    modport slave (
        input  bcd_in, dp_in, blank_en, start, auto_refresh,
        output sdata, sclk, latch, busy, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/display_serializer.sv
`default_nettype none
//==============================================================================
// display_serializer: BCD digits to 7-segment frame, shifted out over sdata/sclk/latch.
// Rev 1.0
//==============================================================================
module display_serializer #(
    parameter int NUM_DIGITS  = 4,
    parameter int CLK_DIV     = 50,
    parameter int LSB_FIRST   = 1,
    parameter int GAP_PERIODS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    display_serializer_if.slave  bus
);
    localparam int c_frame_bits = 8 * NUM_DIGITS;
    localparam int c_gap_cycles = GAP_PERIODS * 2 * CLK_DIV;
    localparam int c_div_max    = (c_gap_cycles > 2 * CLK_DIV) ? c_gap_cycles : 2 * CLK_DIV;
    localparam int c_div_w      = $clog2(c_div_max);
    localparam int c_bit_w      = $clog2(c_frame_bits);

    localparam logic [c_div_w-1:0] c_half         = c_div_w'(CLK_DIV);
    localparam logic [c_div_w-1:0] c_half_last    = c_div_w'(CLK_DIV - 1);
    localparam logic [c_div_w-1:0] c_bit_div_last = c_div_w'(2 * CLK_DIV - 1);
    localparam logic [c_div_w-1:0] c_gap_last     = c_div_w'((c_gap_cycles > 0) ? c_gap_cycles - 1 : 0);
    localparam logic [c_bit_w-1:0] c_bit_last     = c_bit_w'(c_frame_bits - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_LATCH = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t                    r_state;
    logic [c_div_w-1:0]        r_div;
    logic [c_bit_w-1:0]        r_bit;
    logic [c_frame_bits-1:0]   r_shift;
    logic                      r_sdata;
    logic                      r_sclk;
    logic                      r_latch;
    logic                      r_busy;
    logic                      r_frame_done;

    state_t                    w_next_state;
    logic [c_div_w-1:0]        w_next_div;
    logic [c_bit_w-1:0]        w_next_bit;
    logic [c_frame_bits-1:0]   w_next_shift;
    logic [c_frame_bits-1:0]   w_shift_adv;
    logic [c_frame_bits-1:0]   w_frame;
    logic [3:0]                w_digit;
    logic [7:0]                w_seg;
    logic                      w_lead;
    logic                      w_head;
    logic                      w_sdata_nxt;
    logic                      w_sclk_nxt;
    logic                      w_latch_nxt;
    logic                      w_busy_nxt;
    logic                      w_frame_done_nxt;

    // Segment order a,b,c,d,e,f,g,dp from bit 7 down; non-BCD codes show a dash.
    function automatic logic [7:0] seg_lut(input logic [3:0] d);
        case (d)
            4'd0:    seg_lut = 8'hFC;
            4'd1:    seg_lut = 8'h60;
            4'd2:    seg_lut = 8'hDA;
            4'd3:    seg_lut = 8'hF2;
            4'd4:    seg_lut = 8'h66;
            4'd5:    seg_lut = 8'hB6;
            4'd6:    seg_lut = 8'hBE;
            4'd7:    seg_lut = 8'hE0;
            4'd8:    seg_lut = 8'hFE;
            4'd9:    seg_lut = 8'hF6;
            default: seg_lut = 8'h02;
        endcase
    endfunction

    // Blanking runs from the top digit down and stops at the first nonzero nibble.
    always_comb begin
        w_frame = '0;
        w_digit = '0;
        w_seg   = '0;
        w_lead  = bus.blank_en;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_digit = bus.bcd_in[4*i +: 4];
            w_seg   = seg_lut(w_digit);
            if (w_lead && (i != 0) && (w_digit == 4'd0)) begin
                w_seg = 8'h00;
            end else begin
                w_lead = 1'b0;
            end
            w_seg[0] = w_seg[0] | bus.dp_in[i];
            w_frame[8*i +: 8] = w_seg;
        end
    end

    assign w_shift_adv = (LSB_FIRST != 0) ? {1'b0, r_shift[c_frame_bits-1:1]}
                                          : {r_shift[c_frame_bits-2:0], 1'b0};

    always_comb begin
        w_next_state = r_state;
        w_next_div   = r_div;
        w_next_bit   = r_bit;
        w_next_shift = r_shift;
        case (r_state)
            S_IDLE: begin
                if (bus.start || bus.auto_refresh) w_next_state = S_LOAD;
            end
            S_LOAD: begin
                w_next_shift = w_frame;
                w_next_div   = '0;
                w_next_bit   = '0;
                w_next_state = S_SHIFT;
            end
            S_SHIFT: begin
                if (r_div == c_bit_div_last) begin
                    w_next_div = '0;
                    if (r_bit == c_bit_last) begin
                        w_next_state = S_LATCH;
                    end else begin
                        w_next_bit   = r_bit + 1'b1;
                        w_next_shift = w_shift_adv;
                    end
                end else begin
                    w_next_div = r_div + 1'b1;
                end
            end
            S_LATCH: begin
                if (r_div == c_half_last) begin
                    w_next_div = '0;
                    if (bus.auto_refresh && (GAP_PERIODS > 0)) w_next_state = S_GAP;
                    else if (bus.auto_refresh)                 w_next_state = S_LOAD;
                    else                                       w_next_state = S_IDLE;
                end else begin
                    w_next_div = r_div + 1'b1;
                end
            end
            S_GAP: begin
                if (r_div == c_gap_last) begin
                    w_next_div   = '0;
                    w_next_state = bus.auto_refresh ? S_LOAD : S_IDLE;
                end else begin
                    w_next_div = r_div + 1'b1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase

        // Outputs are decoded from next-state values so the pins come straight from flops.
        w_head           = (LSB_FIRST != 0) ? w_next_shift[0] : w_next_shift[c_frame_bits-1];
        w_sdata_nxt      = (w_next_state == S_SHIFT) && w_head;
        w_sclk_nxt       = (w_next_state == S_SHIFT) && (w_next_div >= c_half);
        w_latch_nxt      = (w_next_state == S_LATCH);
        w_busy_nxt       = (w_next_state != S_IDLE);
        w_frame_done_nxt = (w_next_state == S_LATCH) && (w_next_div == c_half_last);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_div        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_sdata      <= 1'b0;
            r_sclk       <= 1'b0;
            r_latch      <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_div        <= w_next_div;
            r_bit        <= w_next_bit;
            r_shift      <= w_next_shift;
            r_sdata      <= w_sdata_nxt;
            r_sclk       <= w_sclk_nxt;
            r_latch      <= w_latch_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    assign bus.sdata      = r_sdata;
    assign bus.sclk       = r_sclk;
    assign bus.latch      = r_latch;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;
endmodule
`default_nettype wire

// File: tb/tb_display_serializer.sv
`default_nettype none
//==============================================================================
// tb_display_serializer: random and directed frames checked against a digit-level model.
// Rev 1.0
//==============================================================================
module tb_display_serializer;
    localparam int ND = 4;
    localparam int CD = 2;
    localparam int GP = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    display_serializer_if #(.NUM_DIGITS(ND)) bus0 ();
    display_serializer_if #(.NUM_DIGITS(ND)) bus1 ();

    display_serializer #(.NUM_DIGITS(ND), .CLK_DIV(CD), .LSB_FIRST(1), .GAP_PERIODS(GP))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    display_serializer #(.NUM_DIGITS(ND), .CLK_DIV(CD), .LSB_FIRST(0), .GAP_PERIODS(GP))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    assign bus1.bcd_in       = bus0.bcd_in;
    assign bus1.dp_in        = bus0.dp_in;
    assign bus1.blank_en     = bus0.blank_en;
    assign bus1.start        = bus0.start;
    assign bus1.auto_refresh = bus0.auto_refresh;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Digit-level reference: segment table, leading-zero rule, dp OR.
    function automatic logic [31:0] ref_frame(input logic [15:0] bcd, input logic [3:0] dp,
                                              input logic blank);
        logic [7:0] lut [10];
        logic [31:0] f;
        logic [7:0] s;
        logic leading;
        int d;
        lut = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};
        f = '0;
        leading = blank;
        for (int i = ND - 1; i >= 0; i--) begin
            d = int'((bcd >> (4 * i)) & 16'hF);
            s = (d < 10) ? lut[d] : 8'h02;
            if (leading && i > 0 && d == 0) s = 8'h00;
            else leading = 1'b0;
            if (dp[i]) s = s | 8'h01;
            f = f | (32'(s) << (8 * i));
        end
        return f;
    endfunction

    // Serial-side monitor: reassembles each frame from sdata at sclk rising edges.
    logic [1:0]  s_sclk, s_sdata, s_latch, s_fd;
    assign s_sclk  = {bus1.sclk, bus0.sclk};
    assign s_sdata = {bus1.sdata, bus0.sdata};
    assign s_latch = {bus1.latch, bus0.latch};
    assign s_fd    = {bus1.frame_done, bus0.frame_done};

    logic [1:0]  prev_sclk = 2'b00;
    logic [31:0] acc [2] = '{32'h0, 32'h0};
    logic [31:0] got_frame [2] = '{32'h0, 32'h0};
    logic [1:0]  first_bit = 2'b00;
    logic [1:0]  got_first = 2'b00;
    int nbits [2]     = '{0, 0};
    int lat_cnt [2]   = '{0, 0};
    int got_bits [2]  = '{0, 0};
    int got_lat [2]   = '{0, 0};
    int fd_count [2]  = '{0, 0};
    int fd_cyc [2]    = '{0, 0};
    int lat_total [2] = '{0, 0};
    int lat_bad [2]   = '{0, 0};
    int cyc = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 2; k++) begin
            prev_sclk[k] <= s_sclk[k];
            if (!rst) begin
                acc[k]     <= '0;
                nbits[k]   <= 0;
                lat_cnt[k] <= 0;
            end else begin
                if (s_sclk[k] && !prev_sclk[k]) begin
                    if (nbits[k] == 0) first_bit[k] <= s_sdata[k];
                    if (k == 0) acc[k][nbits[k] & 31] <= s_sdata[k];
                    else        acc[k] <= {acc[k][30:0], s_sdata[k]};
                    nbits[k] <= nbits[k] + 1;
                end
                if (s_latch[k]) begin
                    lat_total[k] <= lat_total[k] + 1;
                    if (s_sdata[k]) lat_bad[k] <= lat_bad[k] + 1;
                end
                if (s_fd[k]) begin
                    got_frame[k] <= acc[k];
                    got_bits[k]  <= nbits[k];
                    got_lat[k]   <= lat_cnt[k] + (s_latch[k] ? 1 : 0);
                    got_first[k] <= first_bit[k];
                    fd_count[k]  <= fd_count[k] + 1;
                    fd_cyc[k]    <= cyc;
                    acc[k]       <= '0;
                    nbits[k]     <= 0;
                    lat_cnt[k]   <= 0;
                end else if (s_latch[k]) begin
                    lat_cnt[k] <= lat_cnt[k] + 1;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_fd(input int target, input string tag);
        int n;
        n = 0;
        while (fd_count[0] < target && n < 1000) begin
            tick();
            n++;
        end
        check({tag, " frame_done seen"}, 64'(fd_count[0] >= target), 64'd1);
    endtask

    // One start-triggered frame; inputs are scrambled after LOAD and start is re-pulsed mid-frame.
    task automatic run_frame(input logic [15:0] bcd, input logic [3:0] dp, input logic blank,
                             input string tag);
        logic [31:0] exp;
        int f0;
        int n;
        exp = ref_frame(bcd, dp, blank);
        f0  = fd_count[0];
        bus0.bcd_in   = bcd;
        bus0.dp_in    = dp;
        bus0.blank_en = blank;
        bus0.start    = 1'b1;
        tick();
        bus0.start = 1'b0;
        check({tag, " busy at LOAD"}, 64'(bus0.busy), 64'd1);
        tick();
        bus0.bcd_in   = 16'($urandom);
        bus0.dp_in    = 4'($urandom);
        bus0.blank_en = 1'($urandom);
        n = 2;
        while (fd_count[0] == f0 && n < 400) begin
            bus0.start = (n == 60);
            tick();
            n++;
        end
        bus0.start = 1'b0;
        check({tag, " frame_done latency"}, 64'(n), 64'd131);
        check({tag, " lsb frame"}, 64'(got_frame[0]), 64'(exp));
        check({tag, " msb frame"}, 64'(got_frame[1]), 64'(exp));
        check({tag, " sclk rises"}, 64'(got_bits[0]), 64'd32);
        check({tag, " msb sclk rises"}, 64'(got_bits[1]), 64'd32);
        check({tag, " latch cycles"}, 64'(got_lat[0]), 64'd2);
        check({tag, " lsb first bit"}, 64'(got_first[0]), 64'(exp[0]));
        check({tag, " msb first bit"}, 64'(got_first[1]), 64'(exp[31]));
        tick();
        check({tag, " busy after"}, 64'(bus0.busy), 64'd0);
        check({tag, " sclk after"}, 64'(bus0.sclk), 64'd0);
        check({tag, " one frame only"}, 64'(fd_count[0]), 64'(f0 + 1));
    endtask

    initial begin
        int f0;
        int c1;
        int l0;
        int n;
        logic [15:0] rb;
        bus0.bcd_in       = '0;
        bus0.dp_in        = '0;
        bus0.blank_en     = 1'b0;
        bus0.start        = 1'b0;
        bus0.auto_refresh = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("reset sdata", 64'(bus0.sdata), 64'd0);
        check("reset sclk", 64'(bus0.sclk), 64'd0);
        check("reset latch", 64'(bus0.latch), 64'd0);
        check("reset busy", 64'(bus0.busy), 64'd0);
        check("reset frame_done", 64'(bus0.frame_done), 64'd0);
        check("reset busy msb", 64'(bus1.busy), 64'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        check("model 1234", 64'(ref_frame(16'h1234, 4'b0000, 1'b0)), 64'h60DAF266);
        run_frame(16'h1234, 4'b0000, 1'b0, "d1234");
        run_frame(16'h0070, 4'b0100, 1'b1, "blank0070");
        run_frame(16'h0000, 4'b0000, 1'b1, "blank0000");
        run_frame(16'hA9F0, 4'b0000, 1'b1, "invalidA9F0");

        for (int it = 0; it < 8; it++) begin
            rb = '0;
            for (int d = 0; d < ND; d++)
                if ($urandom_range(0, 1) == 1) rb[4*d +: 4] = 4'($urandom_range(0, 15));
            run_frame(rb, 4'($urandom), 1'($urandom), $sformatf("rand%0d", it));
        end

        // Free-running refresh with a mid-frame input change and mid-frame stop.
        f0 = fd_count[0];
        bus0.bcd_in       = 16'h5678;
        bus0.dp_in        = 4'b0001;
        bus0.blank_en     = 1'b0;
        bus0.auto_refresh = 1'b1;
        repeat (40) tick();
        bus0.bcd_in = 16'h0902;
        bus0.blank_en = 1'b1;
        wait_fd(f0 + 1, "auto1");
        check("auto1 frame", 64'(got_frame[0]), 64'(ref_frame(16'h5678, 4'b0001, 1'b0)));
        c1 = fd_cyc[0];
        wait_fd(f0 + 2, "auto2");
        check("auto2 frame", 64'(got_frame[0]), 64'(ref_frame(16'h0902, 4'b0001, 1'b1)));
        check("auto2 spacing", 64'(fd_cyc[0] - c1), 64'd135);
        c1 = fd_cyc[0];
        repeat (40) tick();
        bus0.auto_refresh = 1'b0;
        wait_fd(f0 + 3, "auto3");
        check("auto3 frame", 64'(got_frame[1]), 64'(ref_frame(16'h0902, 4'b0001, 1'b1)));
        check("auto3 spacing", 64'(fd_cyc[0] - c1), 64'd135);
        repeat (300) tick();
        check("auto stopped", 64'(fd_count[0]), 64'(f0 + 3));
        check("auto idle busy", 64'(bus0.busy), 64'd0);

        // Asynchronous reset in the middle of bit 10.
        f0 = fd_count[0];
        l0 = lat_total[0];
        bus0.bcd_in   = 16'h4321;
        bus0.dp_in    = 4'b1010;
        bus0.blank_en = 1'b0;
        bus0.start    = 1'b1;
        tick();
        bus0.start = 1'b0;
        n = 0;
        while (nbits[0] < 10 && n < 200) begin
            tick();
            n++;
        end
        check("reached bit 10", 64'(nbits[0]), 64'd10);
        #2 rst = 1'b0;
        #1;
        check("midreset sdata", 64'(bus0.sdata), 64'd0);
        check("midreset sclk", 64'(bus0.sclk), 64'd0);
        check("midreset busy", 64'(bus0.busy), 64'd0);
        check("midreset latch", 64'(bus0.latch), 64'd0);
        tick();
        tick();
        rst = 1'b1;
        repeat (5) tick();
        check("midreset no latch", 64'(lat_total[0]), 64'(l0));
        check("midreset no frame_done", 64'(fd_count[0]), 64'(f0));
        check("midreset sdata in latch", 64'(lat_bad[0] + lat_bad[1]), 64'd0);
        run_frame(16'h4321, 4'b1010, 1'b0, "after reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire

// File: doc/display_serializer.md
Name: display_serializer

Overview:
- Parametrised successor to the fixed 4-digit BCD-to-7-segment serial sender.
- Converts NUM_DIGITS BCD nibbles plus per-digit decimal points into 8-bit segment codes.
- Optionally blanks leading zeros.
- Shifts the frame out on an explicit sdata/sclk/latch interface to external shift-register display drivers, started by a start pulse or by free-running auto-refresh.

Parameters:
- NUM_DIGITS, 4, number of display digits (1..8); frame length FRAME_BITS = 8*NUM_DIGITS.
- CLK_DIV, 50, clk cycles per sclk half-period (>=1).
- LSB_FIRST, 1, 1 = frame bit 0 shifted first; 0 = frame bit FRAME_BITS-1 first.
- GAP_PERIODS, 1, idle sclk periods (2*CLK_DIV clk each) after latch before the next frame in auto-refresh (>=0).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- bcd_in  in  4*NUM_DIGITS  BCD digits; nibble i = digit i, digit 0 least significant.
- dp_in  in  NUM_DIGITS  decimal point per digit.
- blank_en  in  1  leading-zero blanking enable.
- start  in  1  one-cycle request to send one frame.
- auto_refresh  in  1  when 1, frames repeat continuously.
- sdata  out  1  serial segment data.
- sclk  out  1  shift clock; external driver samples sdata on sclk rising edge.
- latch  out  1  storage-register strobe, high for CLK_DIV cycles after the last bit.
- busy  out  1  high from LOAD through the end of GAP.
- frame_done  out  1  one-cycle pulse at the end of each frame's latch phase.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, sdata=0, sclk=0, latch=0, busy=0, frame_done=0, divider=0, bit counter=0, shift register=0.

Segment encoding (bit7..0 = a,b,c,d,e,f,g,dp):
- Digits 0..9 map to FC, 60, DA, F2, 66, B6, BE, E0, FE, F6.
- Nibbles 10..15 map to 02 (dash).
- Bit 0 = segment bit 0 OR dp_in[i].

Leading-zero blanking:
- When blank_en=1, digits from NUM_DIGITS-1 downward that equal 0 become 00, stopping at the first nonzero or invalid digit.
- Digit 0 is never blanked.
- dp_in is still ORed into blanked digits.

Frame word = {seg[NUM_DIGITS-1], ..., seg[0]}.

FSM states:
- IDLE:
  - sclk=0, latch=0, busy=0.
  - Goes to LOAD on start=1 or auto_refresh=1.
- LOAD (1 clk):
  - Samples bcd_in, dp_in and blank_en.
  - Loads the frame word into the shift register and clears the divider and bit counter.
  - sdata presents the first bit from the next cycle; busy=1 from this cycle.
  - Inputs changing after LOAD do not affect the frame in flight.
- SHIFT:
  - Each bit lasts 2*CLK_DIV clk cycles: sclk=0 for CLK_DIV cycles, then sclk=1 for CLK_DIV cycles.
  - At the end of the high half, sclk returns to 0 and sdata advances to the next bit in the same cycle.
  - After FRAME_BITS bits: go to LATCH, sclk=0.
- LATCH:
  - latch=1 for CLK_DIV cycles, sdata=0.
  - On the last cycle, frame_done=1 for one clk.
  - Then go to GAP if auto_refresh=1 and GAP_PERIODS>0.
  - Otherwise go to LOAD if auto_refresh=1, or to IDLE.
- GAP:
  - Idle for GAP_PERIODS*2*CLK_DIV cycles with busy=1.
  - Then go to LOAD if auto_refresh=1, else IDLE.

Timing and edge cases:
- Latency: start sampled in IDLE in cycle t gives LOAD in t+1 and the first bit on sdata in t+2.
- Total frame time = 1 + FRAME_BITS*2*CLK_DIV + CLK_DIV clk cycles, plus the gap.
- start while busy=1 is ignored (not queued).
- auto_refresh deasserted mid-frame: the current frame completes, then the block goes to IDLE.
- Reset mid-frame: immediate return to reset values; no latch pulse is emitted.
- Divider and bit counters are sized with clog2 of their maximum values, with no wrap beyond the terminal count.

Test Plan (NUM_DIGITS=4, CLK_DIV=2, GAP_PERIODS=1 unless stated):
- Single frame: bcd_in=16'h1234, dp_in=0, blank_en=0, LSB_FIRST=1, one start pulse -> exactly 32 sclk rising edges; bits sampled on those edges assemble to 32'h60DAF266; then one latch pulse of 2 cycles and one frame_done; busy falls; sclk stays 0.
- Ordering: same frame with LSB_FIRST=0 -> first sampled bit = bit 31 of 32'h60DAF266 (=0); full frame reassembled MSB-first equals 32'h60DAF266.
- Blanking: bcd_in=16'h0070, dp_in=4'b0100, blank_en=1 -> frame 32'h0001E0FC (digit 3 blank, digit 2 blank + dp, 7, 0); bcd_in=16'h0000 -> 32'h000000FC.
- Invalid digits: bcd_in=16'hA9F0, blank_en=1 -> 32'h02F602FC (invalid digit 3 not blanked).
- Auto-refresh: auto_refresh=1 for 3 frames -> frame_done pulses spaced by 1+128+2+4 = 135 cycles; bcd_in changed mid-frame appears only in the next frame; clearing auto_refresh mid-frame gives one more frame_done, then IDLE.
- Reset/busy: start during SHIFT has no effect on bit count; rst=0 asserted asynchronously at bit 10 -> outputs zero immediately, no latch; a new start after release sends a full 32-bit frame.
